// File: rtl/mem8x8_ctrl.sv
// ---------------------------------------------------------------------------
// mem8x8_ctrl
// Host-side controller for an 8-row array of bytecell storage cells.
// It turns each host read or write into cell-level strobes. The strobe
// sequence is: setup (row select low, op/data stable), then strobe (one-hot
// row select high), then done (one-cycle ack). Read data is captured from
// the array on the edge that ends the last strobe cycle.
//
// Optional feature macro: READBACK_VERIFY_EN
//   When defined, every write is followed by a verify read of the same row
//   (VSETUP/VSTROBE). The data read back is compared with the written data,
//   and verr is raised together with ack when they differ. When undefined,
//   verr is held at 0 and the port list is unchanged.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst       in   1         synchronous reset, active-high
//   req       in   1         host request (level), sampled only in IDLE
//   we        in   1         1 = write, 0 = read; latched with req
//   addr      in   ADDR_W    row index; latched with req
//   wdata     in   DATA_W    write data; latched with req
//   ack       out  1         one-cycle completion pulse
//   busy      out  1         high in every state except IDLE
//   rdata     out  DATA_W    last read result, held until the next read's ack
//   verr      out  1         readback mismatch, valid with ack
//   mem_sel   out  NUM_ROWS  one-hot row select to the array
//   mem_op    out  1         1 = write, 0 = read/hold
//   mem_inp   out  DATA_W    write data broadcast to all rows
//   mem_outp  in   DATA_W    selected row's output from the array
// ---------------------------------------------------------------------------
module mem8x8_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     ack,
  output logic                     busy,
  output logic [DATA_W-1:0]        rdata,
  output logic                     verr,
  output logic [(2**ADDR_W)-1:0]   mem_sel,
  output logic                     mem_op,
  output logic [DATA_W-1:0]        mem_inp,
  input  logic [DATA_W-1:0]        mem_outp
);

  localparam int NUM_ROWS = 2**ADDR_W;
  localparam int MAX_CYC  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // The counter counts down to zero, so each phase loads (cycles - 1).
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_VSETUP  = 3'd3,
    ST_VSTROBE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
`ifdef READBACK_VERIFY_EN
  logic [DATA_W-1:0]   wdata_r;
`endif

  // One-hot row decode; exactly one bit set for every address.
  function automatic logic [NUM_ROWS-1:0] row_decode(input logic [ADDR_W-1:0] a);
    logic [NUM_ROWS-1:0] v;
    v = {{(NUM_ROWS-1){1'b0}}, 1'b1} << a;
    return v;
  endfunction

  // Transaction FSM with all host- and array-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
`ifdef READBACK_VERIFY_EN
      wdata_r <= {DATA_W{1'b0}};
`endif
      ack     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= {DATA_W{1'b0}};
      verr    <= 1'b0;
      mem_sel <= {NUM_ROWS{1'b0}};
      mem_op  <= 1'b0;
      mem_inp <= {DATA_W{1'b0}};
    end else begin
      ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          mem_sel <= {NUM_ROWS{1'b0}};
          if (req) begin
            we_r    <= we;
            addr_r  <= addr;
`ifdef READBACK_VERIFY_EN
            wdata_r <= wdata;
`endif
            // op/data are changed here while no row is selected.
            mem_op  <= we;
            mem_inp <= we ? wdata : {DATA_W{1'b0}};
            cnt_r   <= SETUP_LOAD;
            busy    <= 1'b1;
            state_r <= ST_SETUP;
          end else begin
            mem_op  <= 1'b0;
            busy    <= 1'b0;
          end
        end

        ST_SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            mem_sel <= row_decode(addr_r);
            cnt_r   <= STROBE_LOAD;
            state_r <= ST_STROBE;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end

        ST_STROBE: begin
          if (cnt_r == CNT_ZERO) begin
            // Deselect and drop op on the same edge.
            // The cell samples the pre-edge values, so the write completes cleanly.
            mem_sel <= {NUM_ROWS{1'b0}};
            mem_op  <= 1'b0;
            if (!we_r) begin
              rdata <= mem_outp;
            end else begin
              rdata <= rdata;
            end
`ifdef READBACK_VERIFY_EN
            if (we_r) begin
              cnt_r   <= SETUP_LOAD;
              state_r <= ST_VSETUP;
            end else begin
              verr    <= 1'b0;
              ack     <= 1'b1;
              state_r <= ST_DONE;
            end
`else
            verr    <= 1'b0;
            ack     <= 1'b1;
            state_r <= ST_DONE;
`endif
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end

`ifdef READBACK_VERIFY_EN
        ST_VSETUP: begin
          if (cnt_r == CNT_ZERO) begin
            mem_sel <= row_decode(addr_r);
            cnt_r   <= STROBE_LOAD;
            state_r <= ST_VSTROBE;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end

        ST_VSTROBE: begin
          if (cnt_r == CNT_ZERO) begin
            // Verify reads never touch rdata; they only set verr.
            mem_sel <= {NUM_ROWS{1'b0}};
            verr    <= (mem_outp != wdata_r);
            ack     <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
`endif

        ST_DONE: begin
          // Any req seen in this state is dropped; a new one is taken in IDLE.
          mem_sel <= {NUM_ROWS{1'b0}};
          mem_op  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          mem_sel <= {NUM_ROWS{1'b0}};
          mem_op  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem8x8_ctrl
// Directed bench for mem8x8_ctrl. It includes a behavioural 8-row array of
// bytecell-equivalent cells. A cell stores inp on a clock edge when both its
// sel and op are high. The array output is the stored value of the selected
// row, or 0 when no row is selected. With READBACK_VERIFY_EN defined, row 3
// bit 0 is stuck at 0.
// ---------------------------------------------------------------------------
module tb_mem8x8_ctrl;

`ifdef READBACK_VERIFY_EN
  localparam int WR_LAT = 7;
`else
  localparam int WR_LAT = 4;
`endif
  localparam int RD_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic       busy;
  logic [7:0] rdata;
  logic       verr;
  logic [7:0] mem_sel;
  logic       mem_op;
  logic [7:0] mem_inp;
  logic [7:0] mem_outp;

  logic [7:0] cells [8] = '{default: 8'h00};

  int errors = 0;
  int checks = 0;

  mem8x8_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .busy     (busy),
    .rdata    (rdata),
    .verr     (verr),
    .mem_sel  (mem_sel),
    .mem_op   (mem_op),
    .mem_inp  (mem_inp),
    .mem_outp (mem_outp)
  );

  always #5 clk = ~clk;

  // Behavioural cell array write port.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_sel[i] && mem_op) begin
`ifdef READBACK_VERIFY_EN
        cells[i] <= (i == 3) ? {mem_inp[7:1], 1'b0} : mem_inp;
`else
        cells[i] <= mem_inp;
`endif
      end
    end
  end

  // Array read mux: OR of the selected rows.
  always_comb begin
    mem_outp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (mem_sel[i]) mem_outp = mem_outp | cells[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for ack; lat = ack cycle or -1.
  task automatic run_txn(input logic w, input logic [2:0] a, input logic [7:0] d,
                         output int lat);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) req = 1'b0;
      if (ack === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ack !== 1'b0)      begin errors++; $display("FAIL rst_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (rdata !== 8'h00)   begin errors++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    checks++; if (verr !== 1'b0)     begin errors++; $display("FAIL rst_verr: got %b want 0", verr); end
    checks++; if (mem_sel !== 8'h00) begin errors++; $display("FAIL rst_sel: got %h want 00", mem_sel); end
    checks++; if (mem_op !== 1'b0)   begin errors++; $display("FAIL rst_op: got %b want 0", mem_op); end
    checks++; if (mem_inp !== 8'h00) begin errors++; $display("FAIL rst_inp: got %h want 00", mem_inp); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int lat;
    req = 1'b1; we = 1'b1; addr = 3'd2; wdata = 8'hAA;
    tick();                                          // cycle 1
    req = 1'b0; wdata = 8'h00;
    checks++; if (mem_sel !== 8'h00) begin errors++; $display("FAIL wr_c1_sel: got %h want 00", mem_sel); end
    checks++; if (mem_op !== 1'b1)   begin errors++; $display("FAIL wr_c1_op: got %b want 1", mem_op); end
    checks++; if (mem_inp !== 8'hAA) begin errors++; $display("FAIL wr_c1_inp: got %h want AA", mem_inp); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL wr_c1_busy: got %b want 1", busy); end
    tick();                                          // cycle 2
    checks++; if (mem_sel !== 8'h04) begin errors++; $display("FAIL wr_c2_sel: got %h want 04", mem_sel); end
    checks++; if (mem_op !== 1'b1)   begin errors++; $display("FAIL wr_c2_op: got %b want 1", mem_op); end
    tick();                                          // cycle 3
    checks++; if (mem_sel !== 8'h04) begin errors++; $display("FAIL wr_c3_sel: got %h want 04", mem_sel); end
    lat = -1;
    for (int c = 4; c <= 20; c++) begin
      tick();
      if (ack === 1'b1) begin lat = c; break; end
    end
    checks++; if (lat != WR_LAT)     begin errors++; $display("FAIL wr_lat: got %0d want %0d", lat, WR_LAT); end
    checks++; if (verr !== 1'b0)     begin errors++; $display("FAIL wr_verr: got %b want 0", verr); end
    checks++; if (mem_sel !== 8'h00) begin errors++; $display("FAIL wr_done_sel: got %h want 00", mem_sel); end
    tick();
    checks++; if (ack !== 1'b0)      begin errors++; $display("FAIL wr_ack_pulse: got %b want 0", ack); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL wr_idle_busy: got %b want 0", busy); end
    checks++; if (cells[2] !== 8'hAA) begin errors++; $display("FAIL wr_cell2: got %h want AA", cells[2]); end
  endtask

  task automatic test_read();
    int lat;
    req = 1'b1; we = 1'b0; addr = 3'd2; wdata = 8'h33;
    tick();                                          // cycle 1
    req = 1'b0;
    checks++; if (mem_sel !== 8'h00) begin errors++; $display("FAIL rd_c1_sel: got %h want 00", mem_sel); end
    checks++; if (mem_op !== 1'b0)   begin errors++; $display("FAIL rd_c1_op: got %b want 0", mem_op); end
    checks++; if (mem_inp !== 8'h00) begin errors++; $display("FAIL rd_c1_inp: got %h want 00", mem_inp); end
    tick();                                          // cycle 2
    checks++; if (mem_sel !== 8'h04) begin errors++; $display("FAIL rd_c2_sel: got %h want 04", mem_sel); end
    checks++; if (mem_op !== 1'b0)   begin errors++; $display("FAIL rd_c2_op: got %b want 0", mem_op); end
    tick();                                          // cycle 3
    checks++; if (mem_sel !== 8'h04) begin errors++; $display("FAIL rd_c3_sel: got %h want 04", mem_sel); end
    tick();                                          // cycle 4
    checks++; if (ack !== 1'b1)      begin errors++; $display("FAIL rd_c4_ack: got %b want 1", ack); end
    checks++; if (rdata !== 8'hAA)   begin errors++; $display("FAIL rd_rdata2: got %h want AA", rdata); end
    tick();
    tick();
    checks++; if (rdata !== 8'hAA)   begin errors++; $display("FAIL rd_hold: got %h want AA", rdata); end
    run_txn(1'b0, 3'd5, 8'hFF, lat);
    checks++; if (lat != RD_LAT)     begin errors++; $display("FAIL rd5_lat: got %0d want %0d", lat, RD_LAT); end
    checks++; if (rdata !== 8'h00)   begin errors++; $display("FAIL rd_rdata5: got %h want 00", rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int ack_n = 0;
    int ack1 = -1;
    int ack2 = -1;
    int sel7 = 0;
    int multi = 0;
    int glitch = 0;
    logic busy_gap = 1'b1;
    logic [7:0] p_inp;
    logic       p_op;
    p_inp = mem_inp; p_op = mem_op;
    req = 1'b1; we = 1'b1; addr = 3'd1; wdata = 8'h11;
    for (int c = 1; c <= 2 * WR_LAT + 3; c++) begin
      tick();
      if (ack === 1'b1) begin
        ack_n++;
        if (ack1 < 0) ack1 = c; else ack2 = c;
      end
      if (mem_sel === 8'h80) sel7++;
      if ($countones(mem_sel) > 1) multi++;
      if (mem_sel !== 8'h00 && (mem_op !== p_op || mem_inp !== p_inp)) glitch++;
      p_op = mem_op; p_inp = mem_inp;
      if (c == WR_LAT + 1) busy_gap = busy;
      if (c == 2) begin addr = 3'd7; wdata = 8'h77; end
      if (c == 3) begin addr = 3'd6; wdata = 8'h66; end
      if (c == WR_LAT + 2) req = 1'b0;
    end
    checks++; if (ack_n != 2)            begin errors++; $display("FAIL b2b_acks: got %0d want 2", ack_n); end
    checks++; if (ack1 != WR_LAT)        begin errors++; $display("FAIL b2b_ack1: got %0d want %0d", ack1, WR_LAT); end
    checks++; if (ack2 != 2 * WR_LAT + 1) begin errors++; $display("FAIL b2b_ack2: got %0d want %0d", ack2, 2 * WR_LAT + 1); end
    checks++; if (busy_gap !== 1'b0)     begin errors++; $display("FAIL b2b_idle_gap: got %b want 0", busy_gap); end
    checks++; if (sel7 != 0)             begin errors++; $display("FAIL b2b_sel7: got %0d want 0", sel7); end
    checks++; if (multi != 0)            begin errors++; $display("FAIL b2b_onehot: got %0d want 0", multi); end
    checks++; if (glitch != 0)           begin errors++; $display("FAIL b2b_glitch: got %0d want 0", glitch); end
    checks++; if (cells[1] !== 8'h11)    begin errors++; $display("FAIL b2b_cell1: got %h want 11", cells[1]); end
    checks++; if (cells[6] !== 8'h66)    begin errors++; $display("FAIL b2b_cell6: got %h want 66", cells[6]); end
    checks++; if (cells[7] !== 8'h00)    begin errors++; $display("FAIL b2b_cell7: got %h want 00", cells[7]); end
    tick();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    req = 1'b1; we = 1'b1; addr = 3'd4; wdata = 8'hCC;
    tick();                                          // cycle 1
    req = 1'b0;
    tick();                                          // cycle 2
    checks++; if (mem_sel !== 8'h10) begin errors++; $display("FAIL rmid_sel_pre: got %h want 10", mem_sel); end
    rst = 1'b1;
    tick();                                          // cycle 3
    rst = 1'b0;
    checks++; if (mem_sel !== 8'h00) begin errors++; $display("FAIL rmid_sel: got %h want 00", mem_sel); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (mem_op !== 1'b0)   begin errors++; $display("FAIL rmid_op: got %b want 0", mem_op); end
    checks++; if (rdata !== 8'h00)   begin errors++; $display("FAIL rmid_rdata: got %h want 00", rdata); end
    if (ack === 1'b1) acks++;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    checks++; if (acks != 0)         begin errors++; $display("FAIL rmid_noack: got %0d want 0", acks); end
  endtask

`ifdef READBACK_VERIFY_EN
  task automatic test_verify();
    int lat;
    run_txn(1'b1, 3'd3, 8'h55, lat);
    checks++; if (lat != 7)        begin errors++; $display("FAIL vfy_lat: got %0d want 7", lat); end
    checks++; if (verr !== 1'b1)   begin errors++; $display("FAIL vfy_err55: got %b want 1", verr); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL vfy_rdata: got %h want 00", rdata); end
    tick();
    run_txn(1'b1, 3'd3, 8'h54, lat);
    checks++; if (lat != 7)        begin errors++; $display("FAIL vfy_lat2: got %0d want 7", lat); end
    checks++; if (verr !== 1'b0)   begin errors++; $display("FAIL vfy_err54: got %b want 0", verr); end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
`ifdef READBACK_VERIFY_EN
    test_verify();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
